serial_mag_cmp_ctrl: RTL and testbench
======================================

Name: serial_mag_cmp_ctrl

Overview:
Controller that compares two WIDTH-bit operands by driving an external 1-bit comparator one bit per clock, MSB first. The comparator produces the 3-bit one-hot code {gt, eq, lt}. The controller stops early at the first unequal bit and reports the result with a start/busy/done handshake. It sits between a requester (bench or top-level FSM) and the combinational 1-bit compare datapath.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32
CW, $clog2(WIDTH+1), width of the bits_used counter; derived, not overridden

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request a compare; sampled only in IDLE
op_a  in  WIDTH  operand A; captured on an accepted start
op_b  in  WIDTH  operand B; captured on an accepted start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result, err and bits_used are valid
result  out  3  final code: [2]=A>B, [1]=A==B, [0]=A<B
err  out  1  comparator returned a non-one-hot code
bits_used  out  CW  number of bit positions compared, 1..WIDTH
cmp_a  out  1  bit of A presented to the comparator
cmp_b  out  1  bit of B presented to the comparator
cmp_c  in  3  comparator output, combinational from cmp_a/cmp_b

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, result=3'b010, err=0, bits_used=0, cmp_a=0, cmp_b=0, shift registers=0, counter=0.
- States: IDLE, RUN, DONE. All outputs are registered except cmp_a/cmp_b.
- cmp_a/cmp_b equal the MSBs of the internal shift registers sa/sb while in RUN, and 0 in other states.
- IDLE:
  - start=1 → sa<=op_a, sb<=op_b, cnt<=1, busy<=1, state<=RUN.
  - start=0 → stay in IDLE.
- RUN: each cycle, sample cmp_c.
  - cmp_c ∈ {100, 001} → result<=cmp_c, err<=0, bits_used<=cnt, go to DONE.
  - cmp_c=010 and cnt==WIDTH → result<=010, err<=0, bits_used<=WIDTH, go to DONE.
  - cmp_c=010 and cnt<WIDTH → shift sa and sb left by 1 (zero fill), cnt<=cnt+1, stay in RUN.
  - cmp_c not one-hot (000, 011, 101, 110, 111) → result<=000, err<=1, bits_used<=cnt, go to DONE.
  - Whenever RUN is left: busy<=0, done<=1.
- DONE: lasts one cycle with done=1, busy=0; then done<=0 and state<=IDLE unconditionally. start asserted in DONE is ignored.
- Latency: if start is sampled at edge 0 and the first differing bit is at position k (1 = MSB), RUN occupies cycles 1..k and done is high in cycle k+1. Worst case (equal operands) gives done in cycle WIDTH+1.
- result, err and bits_used hold their values from done until the next done or reset.
- start while busy or in DONE: ignored; op_a/op_b changes after capture have no effect.
- Reset mid-operation: the next edge forces reset values, the partial compare is discarded and no done pulse is produced.
- Simultaneous rst and start: rst wins.
- cnt never exceeds WIDTH; there is no wrap-around.

Test Plan:
1. Assert rst for 2 cycles with random inputs → busy=0, done=0, result=010, err=0, bits_used=0, cmp_a=cmp_b=0.
2. WIDTH=8, op_a=0xA5, op_b=0x25, start pulse at cycle 0 → done in cycle 2, result=100, bits_used=1, busy high only in cycle 1.
3. op_a=0x3C, op_b=0x3D → done in cycle 9, result=001, bits_used=8; cmp_a/cmp_b sequence per cycle is 0/0,0/0,1/1,1/1,1/1,1/1,0/0,0/1.
4. op_a=op_b=0x5A → result=010, bits_used=8, done in cycle 9. Then 200 random pairs checked against a behavioural A>B / A==B / A<B model, with a back-to-back start issued in the cycle after each DONE.
5. Pulse start again in RUN cycle 2 with different operands → ignored, original result reported. Assert rst in RUN cycle 3 of a later compare → busy=0 next cycle, no done, result=010.
6. Bench overrides cmp_c=011 in RUN cycle 1 → done in cycle 2, err=1, result=000, bits_used=1; the following normal compare returns err=0.

Source files
------------

// File: rtl/serial_mag_cmp_ctrl_if.sv
// Request-side bundle of the serial magnitude compare controller:
// start/operands in, busy/done/result/err/bits_used out.
interface serial_mag_cmp_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    logic             err;
    logic [CW-1:0]    bits_used;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, err, bits_used
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, err, bits_used
    );
endinterface

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial MSB-first magnitude compare controller driving an external
// 1-bit comparator; stops at the first unequal bit.
module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_mag_cmp_ctrl_if.slave   req,
    output logic                   cmp_a,
    output logic                   cmp_b,
    input  logic [2:0]             cmp_c
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sa_nx, sb_nx;
    logic [CW-1:0]    cnt, cnt_nx, used_nx;
    logic             busy_nx, done_nx, err_nx;
    logic [2:0]       res_nx;

    assign cmp_a = (state == RUN) ? sa[WIDTH-1] : 1'b0;
    assign cmp_b = (state == RUN) ? sb[WIDTH-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sa            <= '0;
            sb            <= '0;
            cnt           <= '0;
            req.busy      <= 1'b0;
            req.done      <= 1'b0;
            req.result    <= 3'b010;
            req.err       <= 1'b0;
            req.bits_used <= '0;
        end else begin
            state         <= state_nx;
            sa            <= sa_nx;
            sb            <= sb_nx;
            cnt           <= cnt_nx;
            req.busy      <= busy_nx;
            req.done      <= done_nx;
            req.result    <= res_nx;
            req.err       <= err_nx;
            req.bits_used <= used_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sb_nx    = sb;
        cnt_nx   = cnt;
        busy_nx  = req.busy;
        done_nx  = 1'b0;
        res_nx   = req.result;
        err_nx   = req.err;
        used_nx  = req.bits_used;
        unique case (state)
            IDLE: begin
                if (req.start) begin
                    sa_nx    = req.op_a;
                    sb_nx    = req.op_b;
                    cnt_nx   = CW'(1);
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                unique case (cmp_c)
                    3'b100, 3'b001: begin
                        res_nx   = cmp_c;
                        err_nx   = 1'b0;
                        used_nx  = cnt;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end
                    3'b010: begin
                        if (cnt == CW'(WIDTH)) begin
                            res_nx   = 3'b010;
                            err_nx   = 1'b0;
                            used_nx  = cnt;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = DONE;
                        end else begin
                            sa_nx  = {sa[WIDTH-2:0], 1'b0};
                            sb_nx  = {sb[WIDTH-2:0], 1'b0};
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                    // Any code that is not one-hot means a broken comparator.
                    default: begin
                        res_nx   = 3'b000;
                        err_nx   = 1'b1;
                        used_nx  = cnt;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end
                endcase
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Randomized self-checking bench for serial_mag_cmp_ctrl with a
// behavioural bit comparator and magnitude reference model.
module tb_serial_mag_cmp_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    localparam int K_NONE  = 0;
    localparam int K_START = 1;
    localparam int K_RST   = 2;
    localparam int K_OVR   = 3;

    logic       clk;
    logic       rst;
    logic       cmp_a, cmp_b;
    logic [2:0] cmp_c;
    logic       ovr_en;
    logic [2:0] ovr_code;
    int         checks;
    int         failures;

    serial_mag_cmp_ctrl_if #(.WIDTH(W)) bus ();

    serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.slave),
        .cmp_a (cmp_a),
        .cmp_b (cmp_b),
        .cmp_c (cmp_c)
    );

    // External 1-bit comparator, optionally overridden by the bench.
    assign cmp_c = ovr_en ? ovr_code :
                   {cmp_a & ~cmp_b, cmp_a == cmp_b, ~cmp_a & cmp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            bus.start = 1'($urandom);
            bus.op_a  = W'($urandom);
            bus.op_b  = W'($urandom);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || cmp_a !== 1'b0 ||
            cmp_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b cmp=%b%b want 0 0 00",
                     bus.busy, bus.done, cmp_a, cmp_b);
        end
        checks++;
        if (bus.result !== 3'b010 || bus.err !== 1'b0 ||
            bus.bits_used !== '0) begin
            failures++;
            $display("FAIL reset_result result=%b err=%b used=%0d want 010 0 0",
                     bus.result, bus.err, bus.bits_used);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
    endtask

    // One compare transaction with an optional disturbance at RUN cycle inj.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int kind, input int inj,
                           input logic [2:0] code, input string name);
        int         k;
        int         k_end;
        int         last;
        int         n;
        bit         found;
        logic [2:0] exp_res;
        logic       exp_err;
        logic       exp_busy;
        logic       exp_done;
        logic       ea, eb;

        k     = W;
        found = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && a[i] != b[i]) begin
                k     = W - i;
                found = 1;
            end
        end
        exp_res = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
        exp_err = 1'b0;
        if (kind == K_OVR) begin
            k       = inj;
            exp_res = 3'b000;
            exp_err = 1'b1;
        end
        k_end = (kind == K_RST) ? inj : k;
        last  = (kind == K_RST) ? inj + 4 : k + 1;

        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);

        n = 0;
        while (n < last) begin
            @(negedge clk);
            n++;
            exp_busy = (n <= k_end) && !(kind == K_RST && n > inj);
            exp_done = (kind != K_RST) && (n == k + 1);
            ea = (n <= k_end) ? a[W-n] : 1'b0;
            eb = (n <= k_end) ? b[W-n] : 1'b0;
            checks++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                failures++;
                $display("FAIL %s_hs cyc=%0d busy=%b done=%b want %b %b",
                         name, n, bus.busy, bus.done, exp_busy, exp_done);
            end
            checks++;
            if (cmp_a !== ea || cmp_b !== eb) begin
                failures++;
                $display("FAIL %s_bits cyc=%0d cmp=%b%b want %b%b",
                         name, n, cmp_a, cmp_b, ea, eb);
            end
            if (exp_done) begin
                checks++;
                if (bus.result !== exp_res || bus.err !== exp_err ||
                    bus.bits_used !== CW'(k)) begin
                    failures++;
                    $display("FAIL %s_res result=%b err=%b used=%0d want %b %b %0d",
                             name, bus.result, bus.err, bus.bits_used,
                             exp_res, exp_err, k);
                end
            end
            if (kind == K_RST && n == inj + 1) begin
                checks++;
                if (bus.result !== 3'b010 || bus.err !== 1'b0 ||
                    bus.bits_used !== '0) begin
                    failures++;
                    $display("FAIL %s_rst result=%b err=%b used=%0d want 010 0 0",
                             name, bus.result, bus.err, bus.bits_used);
                end
                rst = 1'b0;
            end
            if (kind == K_START && n == inj) begin
                bus.start = 1'b1;
                bus.op_a  = ~a;
                bus.op_b  = b ^ W'(1);
            end
            if (kind == K_START && n == inj + 1) bus.start = 1'b0;
            if (kind == K_RST && n == inj) rst = 1'b1;
            if (kind == K_OVR && n == inj) begin
                ovr_en   = 1'b1;
                ovr_code = code;
            end
            if (kind == K_OVR && n == inj + 1) ovr_en = 1'b0;
        end
        if (kind == K_OVR) ovr_en = 1'b0;
        // A start raised during DONE must be ignored by the controller.
        if (kind == K_NONE) begin
            bus.start = 1'b1;
            bus.op_a  = W'($urandom);
            bus.op_b  = W'($urandom);
        end
    endtask

    task automatic test_first_bit();
        run_cmp(8'hA5, 8'h25, K_NONE, 0, 3'b000, "first_bit");
    endtask

    task automatic test_last_bit();
        run_cmp(8'h3C, 8'h3D, K_NONE, 0, 3'b000, "last_bit");
    endtask

    task automatic test_equal();
        run_cmp(8'h5A, 8'h5A, K_NONE, 0, 3'b000, "equal");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            run_cmp(a, b, K_NONE, 0, 3'b000, "random");
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_start_ignored();
        run_cmp(8'h5A, 8'h5A, K_START, 2, 3'b000, "start_in_run");
    endtask

    task automatic test_mid_reset();
        run_cmp(8'h5A, 8'h5A, K_RST, 3, 3'b000, "mid_reset");
    endtask

    task automatic test_bad_code();
        run_cmp(8'h81, 8'h80, K_OVR, 1, 3'b011, "bad_code");
        run_cmp(8'h81, 8'h80, K_NONE, 0, 3'b000, "after_err");
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        ovr_en    = 1'b0;
        ovr_code  = 3'b000;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        test_reset();
        test_first_bit();
        test_last_bit();
        test_equal();
        test_back_to_back();
        test_start_ignored();
        test_mid_reset();
        test_bad_code();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
